// File: rtl/mix_cols_engine.sv
// mix_cols_engine: handshaked AES MixColumns / InvMixColumns unit.
// One 128-bit state is accepted, then COLS_PER_CYCLE columns are transformed in place per
// clock until all four are done; the result is held until downstream takes it.
module mix_cols_engine #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : gen_bad_cols
    $error("mix_cols_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // Counter step and value of the final group; a step of 4 wraps to 0 in two bits.
  localparam logic [1:0] Step    = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LastCnt = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e       state_q;
  logic [127:0] work_q;
  logic [127:0] work_calc;
  logic [1:0]   cnt_q;
  logic         inv_q;
  logic         out_valid_q;
  logic         busy_q;
  logic         accept;

  // Multiply by 2 in GF(2^8) modulo 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (8'h1b & {8{a[7]}});
  endfunction

  // Multiply by a 4-bit constant; constant k collapses to a fixed XOR network.
  function automatic logic [7:0] mul_by(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return ({8{k[0]}} & a) ^ ({8{k[1]}} & x2) ^ ({8{k[2]}} & x4) ^ ({8{k[3]}} & x8);
  endfunction

  // One column transform; byte 0 is the MSB byte of the column.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0]  s [4];
    logic [31:0] res;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      s[i] = col[31 - 8 * i -: 8];
    end
    for (int i = 0; i < 4; i++) begin
      logic [7:0] fwd;
      logic [7:0] bwd;
      fwd = mul_by(s[i], 4'd2) ^ mul_by(s[(i + 1) % 4], 4'd3) ^ s[(i + 2) % 4] ^ s[(i + 3) % 4];
      bwd = mul_by(s[i], 4'd14) ^ mul_by(s[(i + 1) % 4], 4'd11) ^
            mul_by(s[(i + 2) % 4], 4'd13) ^ mul_by(s[(i + 3) % 4], 4'd9);
      res[31 - 8 * i -: 8] = inv ? bwd : fwd;
    end
    return res;
  endfunction

  assign in_ready  = ~rst & ((state_q == StIdle) | ((state_q == StDone) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign out_state = work_q;
  assign busy      = busy_q;

  // Work register with the current column group replaced by its transformed value.
  always_comb begin
    work_calc = work_q;
    for (int g = 0; g < int'(COLS_PER_CYCLE) && g < 4; g++) begin
      logic [1:0] idx;
      idx = cnt_q + 2'(g);
      work_calc[(3 - int'(idx)) * 32 +: 32] = mix_col(work_q[(3 - int'(idx)) * 32 +: 32], inv_q);
    end
  end

  // Control FSM with registered out_valid/busy and the in-place work register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      work_q      <= '0;
      cnt_q       <= '0;
      inv_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            work_q  <= in_state;
            inv_q   <= in_inv;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StCalc;
          end
        end
        StCalc: begin
          work_q <= work_calc;
          cnt_q  <= cnt_q + Step;
          if (cnt_q == LastCnt) begin
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (accept) begin
              // Result handshake and next accept share this edge.
              work_q  <= in_state;
              inv_q   <= in_inv;
              cnt_q   <= '0;
              state_q <= StCalc;
            end else begin
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_cols_engine.sv
// Bench for mix_cols_engine: three instances (1, 2 and 4 columns per cycle) with a
// queue-based scoreboard checked by an independent monitor process.
module tb_mix_cols_engine;

  localparam int NU = 3;

  localparam logic [127:0] V0  = 128'hdb135345_f20a225c_01010101_2d26314c;
  localparam logic [127:0] V1  = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
  localparam logic [127:0] C6  = 128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6;
  localparam logic [127:0] D4  = 128'hd4d4d4d5_d4d4d4d5_d4d4d4d5_d4d4d4d5;
  localparam logic [127:0] D5  = 128'hd5d5d7d6_d5d5d7d6_d5d5d7d6_d5d5d7d6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         iv   [NU];
  logic         ir   [NU];
  logic         ii   [NU];
  logic         ov   [NU];
  logic         ordy [NU];
  logic         bsy  [NU];
  logic [127:0] st_in  [NU];
  logic [127:0] st_out [NU];

  logic [127:0] exp_q [NU][$];
  int           acc_q [NU][$];

  // Driver-owned check requests consumed by the monitor.
  bit chk_ir  [NU];
  bit exp_ir  [NU];
  bit chk_rst [NU];
  int tmo_cnt = 0;

  // Monitor-owned counters.
  int tests = 0;
  int fails = 0;
  int tmo_seen = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NU; g++) begin : gen_dut
    mix_cols_engine #(
      .COLS_PER_CYCLE(g == 0 ? 1 : (g == 1 ? 2 : 4))
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (iv[g]),
      .in_ready (ir[g]),
      .in_state (st_in[g]),
      .in_inv   (ii[g]),
      .out_valid(ov[g]),
      .out_ready(ordy[g]),
      .out_state(st_out[g]),
      .busy     (bsy[g])
    );
  end

  function automatic int lat(input int u);
    return (u == 0) ? 4 : ((u == 1) ? 2 : 1);
  endfunction

  // Reference: shift-and-add GF(2^8) multiply, then matrix-vector product per column.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
    logic [7:0]   k [4];
    logic [127:0] r;
    if (inv) begin
      k[0] = 8'd14; k[1] = 8'd11; k[2] = 8'd13; k[3] = 8'd9;
    end else begin
      k[0] = 8'd2;  k[1] = 8'd3;  k[2] = 8'd1;  k[3] = 8'd1;
    end
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        logic [7:0] acc;
        acc = '0;
        for (int j = 0; j < 4; j++) begin
          acc = acc ^ gm(s[127 - 32 * c - 8 * ((i + j) % 4) -: 8], k[j]);
        end
        r[127 - 32 * c - 8 * i -: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic cmp(input string name, input int u, input logic [127:0] act,
                     input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s unit%0d: got %h required %h", name, u, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on each output handshake and checks hold/latency.
  initial begin : monitor
    bit lat_done [NU];
    bit prev_ov  [NU];
    bit prev_rdy [NU];
    for (int u = 0; u < NU; u++) begin
      lat_done[u] = 1'b0;
      prev_ov[u]  = 1'b0;
      prev_rdy[u] = 1'b0;
    end
    forever begin
      @(negedge clk);
      if (tmo_seen != tmo_cnt) begin
        tests++;
        fails++;
        tmo_seen++;
      end
      for (int u = 0; u < NU; u++) begin
        if (chk_ir[u]) cmp("in_ready", u, 128'(ir[u]), 128'(exp_ir[u]));
        if (rst) begin
          prev_ov[u]  = 1'b0;
          lat_done[u] = 1'b0;
        end else begin
          if (chk_rst[u]) begin
            cmp("rst_out_valid", u, 128'(ov[u]), 128'(0));
            cmp("rst_out_state", u, st_out[u], 128'(0));
            cmp("rst_busy", u, 128'(bsy[u]), 128'(0));
          end
          if (prev_ov[u] && !prev_rdy[u]) cmp("hold_valid", u, 128'(ov[u]), 128'(1));
          if (ov[u]) begin
            if (exp_q[u].size() == 0) begin
              tests++;
              fails++;
              $display("FAIL unexpected_output unit%0d: got out_valid=1 state %h required none",
                       u, st_out[u]);
            end else begin
              if (!lat_done[u]) begin
                cmp("latency", u, 128'(cyc - acc_q[u][0]), 128'(lat(u)));
                lat_done[u] = 1'b1;
              end
              cmp("out_state", u, st_out[u], exp_q[u][0]);
              if (ordy[u]) begin
                void'(exp_q[u].pop_front());
                void'(acc_q[u].pop_front());
                lat_done[u] = 1'b0;
              end
            end
          end
          prev_ov[u]  = ov[u];
          prev_rdy[u] = ordy[u];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic timeout(input string what, input int u);
    $display("FAIL timeout_%s unit%0d: got no handshake, required one within the budget",
             what, u);
    tmo_cnt++;
  endtask

  task automatic send(input int u, input logic [127:0] s, input logic inv,
                      input logic [127:0] e);
    tick();
    iv[u]    = 1'b1;
    st_in[u] = s;
    ii[u]    = inv;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ir[u]) begin
        exp_q[u].push_back(e);
        acc_q[u].push_back(cyc + 1);
        return;
      end
      tick();
    end
    timeout("send", u);
  endtask

  task automatic idle_in(input int u);
    tick();
    iv[u] = 1'b0;
  endtask

  task automatic drain(input int u);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (exp_q[u].size() == 0 && !bsy[u]) return;
    end
    timeout("drain", u);
  endtask

  task automatic wait_valid(input int u);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (ov[u]) return;
    end
    timeout("wait_valid", u);
  endtask

  initial begin : driver
    bit acc [NU];
    for (int u = 0; u < NU; u++) begin
      iv[u] = 1'b0; ii[u] = 1'b0; st_in[u] = '0; ordy[u] = 1'b1; acc[u] = 1'b0;
    end

    // Reset: in_ready low during reset, reset values and in_ready high just after.
    tick();
    for (int u = 0; u < NU; u++) begin chk_ir[u] = 1'b1; exp_ir[u] = 1'b0; end
    tick();
    rst = 1'b0;
    for (int u = 0; u < NU; u++) begin exp_ir[u] = 1'b1; chk_rst[u] = 1'b1; end
    tick();
    for (int u = 0; u < NU; u++) begin chk_ir[u] = 1'b0; chk_rst[u] = 1'b0; end

    // Forward vector on the 1-column unit, inverse vector on every unit.
    send(0, V0, 1'b0, V1);
    idle_in(0);
    drain(0);
    for (int u = 0; u < NU; u++) begin
      send(u, V1, 1'b1, V0);
      idle_in(u);
      drain(u);
    end

    // Backpressure: result held 10 cycles while a new state is offered.
    tick();
    ordy[0] = 1'b0;
    send(0, V0, 1'b0, V1);
    idle_in(0);
    wait_valid(0);
    tick();
    iv[0] = 1'b1; st_in[0] = V1; ii[0] = 1'b1;
    chk_ir[0] = 1'b1; exp_ir[0] = 1'b0;
    repeat (10) begin
      @(negedge clk);
      tick();
    end
    ordy[0] = 1'b1;
    exp_ir[0] = 1'b1;
    @(negedge clk);
    if (ir[0]) begin
      exp_q[0].push_back(V0);
      acc_q[0].push_back(cyc + 1);
    end else begin
      timeout("bp_accept", 0);
    end
    tick();
    iv[0] = 1'b0;
    chk_ir[0] = 1'b0;
    drain(0);

    // Back-to-back on the 4-column unit with alternating direction.
    send(2, C6, 1'b1, C6);
    send(2, D4, 1'b0, D5);
    send(2, D5, 1'b1, D4);
    send(2, C6, 1'b0, C6);
    send(2, D5, 1'b1, D4);
    idle_in(2);
    drain(2);

    // Reset mid-computation aborts the transaction; the next one completes.
    send(0, V0, 1'b0, V1);
    idle_in(0);
    tick();
    rst = 1'b1;
    exp_q[0].delete();
    acc_q[0].delete();
    chk_ir[0] = 1'b1; exp_ir[0] = 1'b0;
    tick();
    rst = 1'b0;
    exp_ir[0] = 1'b1; chk_rst[0] = 1'b1;
    tick();
    chk_ir[0] = 1'b0; chk_rst[0] = 1'b0;
    send(0, V1, 1'b1, V0);
    idle_in(0);
    drain(0);

    // Random traffic with random valid/ready on all units at once.
    for (int n = 0; n < 25000; n++) begin
      tick();
      for (int u = 0; u < NU; u++) begin
        if (!iv[u] || acc[u]) begin
          if ($urandom_range(0, 3) != 0) begin
            iv[u]    = 1'b1;
            st_in[u] = {$urandom, $urandom, $urandom, $urandom};
            ii[u]    = 1'($urandom_range(0, 1));
          end else begin
            iv[u] = 1'b0;
          end
        end
        ordy[u] = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      for (int u = 0; u < NU; u++) begin
        acc[u] = iv[u] && ir[u];
        if (acc[u]) begin
          exp_q[u].push_back(model(st_in[u], ii[u]));
          acc_q[u].push_back(cyc + 1);
        end
      end
    end
    tick();
    for (int u = 0; u < NU; u++) begin iv[u] = 1'b0; ordy[u] = 1'b1; end
    for (int u = 0; u < NU; u++) drain(u);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
